// File: rtl/config_divider_8bit_seq.sv
// Multi-cycle signed restoring divider: one DATA_WIDTH division or two DATA_WIDTH/2 lane divisions.
// Define CONFIG_DIVIDER_STATUS_EN to add the div_by_zero_o / overflow_o status outputs.
module config_divider_8bit_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  halved_precision_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o
`ifdef CONFIG_DIVIDER_STATUS_EN
    ,
    output logic [1:0]            div_by_zero_o,
    output logic [1:0]            overflow_o
`endif
);
    localparam int W  = DATA_WIDTH;
    localparam int L  = DATA_WIDTH / 2;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
    state_t state, state_nx;

    logic                halved_q;
    logic [1:0]          sa_q, sb_q, dz_q;
    logic [W-1:0]        dvd_q;
    logic [1:0][W-1:0]   qr_q, rem_q, dv_q;
    logic [CW-1:0]       cnt_q;

    logic [1:0]          sa_d, sb_d, dz_d;
    logic [1:0][W-1:0]   mag_a_d, mag_b_d;
    logic [L-1:0]        la, lb, ma, mb;

    logic [1:0][W-1:0]   qr_step, rem_step;
    logic [W:0]          shifted, trial;

    logic [W-1:0]        quo_d, rem_d;
    logic [L-1:0]        lq, lr, ld;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid_i && in_ready_o) state_nx = CALC;
            CALC:    if (cnt_q == CW'(1))          state_nx = SIGN;
            SIGN:                                  state_nx = DONE;
            DONE:    if (out_valid_o && out_ready_i) state_nx = IDLE;
            default:                               state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state == IDLE);
        out_valid_o = (state == DONE);
    end

    // Halved lanes are left-aligned so the same W-bit shift register serves both modes.
    always_comb begin
        sa_d = '0; sb_d = '0; dz_d = '0;
        mag_a_d = '0; mag_b_d = '0;
        la = '0; lb = '0; ma = '0; mb = '0;
        if (halved_precision_i) begin
            for (int unsigned i = 0; i < 2; i++) begin
                la = dividend_i[i*L +: L];
                lb = divisor_i[i*L +: L];
                sa_d[i] = la[L-1];
                sb_d[i] = lb[L-1];
                ma = la[L-1] ? -la : la;
                mb = lb[L-1] ? -lb : lb;
                mag_a_d[i] = {ma, {L{1'b0}}};
                mag_b_d[i] = {{L{1'b0}}, mb};
                dz_d[i] = (lb == '0);
            end
        end else begin
            sa_d[0] = dividend_i[W-1];
            sb_d[0] = divisor_i[W-1];
            mag_a_d[0] = dividend_i[W-1] ? -dividend_i : dividend_i;
            mag_b_d[0] = divisor_i[W-1] ? -divisor_i : divisor_i;
            dz_d[0] = (divisor_i == '0);
        end
    end

    always_comb begin
        qr_step = qr_q; rem_step = rem_q;
        shifted = '0; trial = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            shifted = {rem_q[i], qr_q[i][W-1]};
            trial   = shifted - {1'b0, dv_q[i]};
            if (trial[W]) begin
                rem_step[i] = shifted[W-1:0];
                qr_step[i]  = {qr_q[i][W-2:0], 1'b0};
            end else begin
                rem_step[i] = trial[W-1:0];
                qr_step[i]  = {qr_q[i][W-2:0], 1'b1};
            end
        end
    end

    // Most-negative / -1 needs no special case: the magnitude quotient wraps to most-negative.
    always_comb begin
        quo_d = '0; rem_d = '0;
        lq = '0; lr = '0; ld = '0;
        if (halved_q) begin
            for (int unsigned i = 0; i < 2; i++) begin
                lq = qr_q[i][L-1:0];
                lr = rem_q[i][L-1:0];
                ld = dvd_q[i*L +: L];
                if (dz_q[i]) begin
                    quo_d[i*L +: L] = '1;
                    rem_d[i*L +: L] = ld;
                end else begin
                    quo_d[i*L +: L] = (sa_q[i] ^ sb_q[i]) ? -lq : lq;
                    rem_d[i*L +: L] = sa_q[i] ? -lr : lr;
                end
            end
        end else if (dz_q[0]) begin
            quo_d = '1;
            rem_d = dvd_q;
        end else begin
            quo_d = (sa_q[0] ^ sb_q[0]) ? -qr_q[0] : qr_q[0];
            rem_d = sa_q[0] ? -rem_q[0] : rem_q[0];
        end
    end

`ifdef CONFIG_DIVIDER_STATUS_EN
    logic [1:0] ov_d;
    always_comb begin
        ov_d = '0;
        if (halved_q) begin
            for (int unsigned i = 0; i < 2; i++)
                ov_d[i] = !dz_q[i] && sa_q[i] && sb_q[i] &&
                          (qr_q[i][L-1:0] == {1'b1, {(L-1){1'b0}}});
        end else begin
            ov_d[0] = !dz_q[0] && sa_q[0] && sb_q[0] &&
                      (qr_q[0] == {1'b1, {(W-1){1'b0}}});
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halved_q    <= 1'b0;
            sa_q        <= '0;
            sb_q        <= '0;
            dz_q        <= '0;
            dvd_q       <= '0;
            qr_q        <= '0;
            rem_q       <= '0;
            dv_q        <= '0;
            cnt_q       <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
`ifdef CONFIG_DIVIDER_STATUS_EN
            div_by_zero_o <= '0;
            overflow_o    <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    halved_q <= halved_precision_i;
                    sa_q     <= sa_d;
                    sb_q     <= sb_d;
                    dz_q     <= dz_d;
                    dvd_q    <= dividend_i;
                    qr_q     <= mag_a_d;
                    rem_q    <= '0;
                    dv_q     <= mag_b_d;
                    cnt_q    <= halved_precision_i ? CW'(L) : CW'(W);
                end
                CALC: begin
                    qr_q  <= qr_step;
                    rem_q <= rem_step;
                    cnt_q <= cnt_q - CW'(1);
                end
                SIGN: begin
                    quotient_o  <= quo_d;
                    remainder_o <= rem_d;
`ifdef CONFIG_DIVIDER_STATUS_EN
                    div_by_zero_o <= dz_q;
                    overflow_o    <= ov_d;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/config_divider_8bit_seq.md
Name: config_divider_8bit_seq

Overview:
Multi-cycle signed integer divider. It is the inverse companion of the configurable-precision 8-bit multiplier.
- Full mode: one DATA_WIDTH-bit division.
- Halved mode: two independent DATA_WIDTH/2-bit divisions in parallel lanes (upper and lower halves).
- Sits next to the multiplier in the datapath, for requantization and scaling.
- valid/ready on both sides; restoring division on magnitudes, one quotient bit per cycle.

Parameters:
DATA_WIDTH, 8, operand/result width; must be even and >= 4; lane width L = DATA_WIDTH/2

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
in_valid_i  input  1  operands valid
in_ready_o  output  1  block can accept operands
dividend_i  input  DATA_WIDTH  signed dividend; halved mode: {lane1, lane0}
divisor_i  input  DATA_WIDTH  signed divisor; halved mode: {lane1, lane0}
halved_precision_i  input  1  0 = one full-width division, 1 = two L-bit lane divisions
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
quotient_o  output  DATA_WIDTH  signed quotient; halved mode: {q1, q0}
remainder_o  output  DATA_WIDTH  signed remainder; halved mode: {r1, r0}

Behaviour:
- Reset (async, active-low): state IDLE, in_ready_o=1, out_valid_o=0, quotient_o=0, remainder_o=0, all internal registers 0.
- States:
  - IDLE -> CALC on in_valid_i && in_ready_o.
  - CALC -> SIGN after N steps (N = DATA_WIDTH in full mode, L in halved mode).
  - SIGN -> DONE after 1 cycle.
  - DONE -> IDLE on out_valid_o && out_ready_i.
- in_ready_o = (state==IDLE).
- out_valid_o = (state==DONE), registered.
- Accept edge:
  - Latch halved_precision_i and both operand signs per lane.
  - Load magnitudes; iteration counter = N.
  - Inputs are ignored after acceptance until back in IDLE.
- CALC: one restoring step per cycle per active lane (shift remainder, trial subtract, set quotient bit). Halved mode runs both lanes concurrently on L-bit magnitudes.
- SIGN: apply sign correction and load the output registers.
- Latency: out_valid_o rises exactly N+1 cycles after the accept edge (9 full, 5 halved). Latency does not depend on operand values.
- Arithmetic (per lane, width W = DATA_WIDTH or L, two's complement):
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign; |r| < |d|.
  - dividend = q*d + r.
- Divide by zero: q = all ones (-1), r = dividend. Constant latency still applies.
- Overflow, most-negative / -1: q = most-negative, r = 0.
- In halved mode each lane handles its special cases independently.
- Backpressure: in DONE with out_ready_i=0, quotient_o, remainder_o and out_valid_o hold stable. in_ready_o stays 0.
- Output handshake edge:
  - Go to IDLE; out_valid_o=0 the next cycle.
  - quotient_o/remainder_o keep their last values.
  - No new operand can be accepted on the same edge as an output handshake.
- halved_precision_i changes while not in IDLE have no effect.
- Reset asserted mid-CALC/SIGN/DONE: immediate return to the reset state. The in-flight result is discarded and is never presented.

Optional Feature:
Macro CONFIG_DIVIDER_STATUS_EN.
- Defined: adds outputs div_by_zero_o [1:0] and overflow_o [1:0].
  - Full mode: bit0 only; bit1 = 0.
  - Halved mode: bit1 = lane1, bit0 = lane0.
  - Both outputs are registered with the results, valid while out_valid_o=1, and reset to 0.
- Undefined: ports absent. Result values are identical in both builds.

Test Plan:
1. Full, 100 / 7 -> quotient_o=14, remainder_o=2; out_valid_o exactly 9 cycles after accept; in_ready_o=0 throughout.
2. Full signed: -100 / 7 -> q=0xF2 (-14), r=0xFE (-2). -128 / -1 -> q=0x80, r=0x00 (overflow_o=01 when macro defined).
3. Full, 37 / 0 -> q=0xFF, r=0x25 (div_by_zero_o=01 when macro defined); latency still 9.
4. Halved, dividend 0x78 ({7,-8}), divisor 0x23 ({2,3}) -> quotient_o=0x3E ({3,-2}), remainder_o=0x1E ({1,-2}); latency 5. Then dividend 0x8F, divisor 0xF0 -> lane1 -8/-1: q1=0x8, r1=0; lane0 -1/0: q0=0xF, r0=0xF.
5. Backpressure: 100 / 7 with out_ready_i=0 for 3 cycles in DONE -> outputs stable, in_ready_o=0. Raise out_ready_i -> in_ready_o=1 the next cycle; back-to-back request accepted then.
6. Reset pulse at CALC step 3 -> all outputs 0 and in_ready_o=1 after release. Next request 50 / 5 returns q=10, r=0 in 9 cycles, with no stale result emitted.
